// File: rtl/decode_queue.sv
// decode_queue: fetch-to-issue instruction buffer with
// multi-slot pre-decode and in-order pairing rules.
module decode_queue #(
  parameter int DEPTH   = 8,
  parameter int FETCH_W = 2,
  parameter int ISSUE_W = 2
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         flush,
  input  logic                         fetch_valid,
  input  logic [$clog2(FETCH_W+1)-1:0] fetch_cnt,
  input  logic [32*FETCH_W-1:0]        fetch_pc,
  input  logic [32*FETCH_W-1:0]        fetch_inst,
  output logic                         fetch_ready,
  output logic [ISSUE_W-1:0]           issue_valid,
  output logic [32*ISSUE_W-1:0]        issue_pc,
  output logic [32*ISSUE_W-1:0]        issue_inst,
  output logic [5*ISSUE_W-1:0]         issue_waddr,
  output logic [10*ISSUE_W-1:0]        issue_raddr,
  output logic [6*ISSUE_W-1:0]         issue_class,
  input  logic                         issue_accept,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH+1);
  localparam int FCW = $clog2(FETCH_W+1);

  typedef struct packed {
    logic [4:0] waddr;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       serial;
    logic       branch;
    logic       mem;
    logic       hilo;
    logic       cp0;
    logic       inv;
  } dec_t;

  function automatic dec_t predecode(input logic [31:0] ins);
    dec_t       d;
    logic [4:0] rs, rt, rd;
    logic [5:0] fn;
    rs = ins[25:21];
    rt = ins[20:16];
    rd = ins[15:11];
    fn = ins[5:0];
    d  = '0;
    unique case (ins[31:26])
      6'h00: begin
        unique case (fn)
          6'h00, 6'h02, 6'h03: begin
            d.waddr = rd; d.rt = rt;
          end
          6'h04, 6'h06, 6'h07: begin
            d.waddr = rd; d.rs = rs; d.rt = rt;
          end
          6'h08: begin
            d.rs = rs; d.branch = 1'b1;
          end
          6'h09: begin
            d.waddr = 5'd31; d.rs = rs;
            d.branch = 1'b1;
          end
          6'h0c, 6'h0d: d.serial = 1'b1;
          6'h10, 6'h12: begin
            d.waddr = rd; d.hilo = 1'b1;
          end
          6'h11, 6'h13: begin
            d.rs = rs; d.hilo = 1'b1;
          end
          6'h18, 6'h19, 6'h1a, 6'h1b: begin
            d.rs = rs; d.rt = rt; d.hilo = 1'b1;
          end
          6'h20, 6'h21, 6'h22, 6'h23,
          6'h24, 6'h25, 6'h26, 6'h27,
          6'h2a, 6'h2b: begin
            d.waddr = rd; d.rs = rs; d.rt = rt;
          end
          default: d.inv = 1'b1;
        endcase
      end
      6'h01: begin
        unique case (rt)
          5'h00, 5'h01: begin
            d.rs = rs; d.branch = 1'b1;
          end
          5'h10, 5'h11: begin
            d.rs = rs; d.branch = 1'b1;
            d.waddr = 5'd31;
          end
          default: d.inv = 1'b1;
        endcase
      end
      6'h02: d.branch = 1'b1;
      6'h03: begin
        d.waddr = 5'd31; d.branch = 1'b1;
      end
      6'h04, 6'h05: begin
        d.rs = rs; d.rt = rt; d.branch = 1'b1;
      end
      6'h06, 6'h07: begin
        d.rs = rs; d.branch = 1'b1;
      end
      6'h08, 6'h09, 6'h0a, 6'h0b,
      6'h0c, 6'h0d, 6'h0e: begin
        d.waddr = rt; d.rs = rs;
      end
      6'h0f: d.waddr = rt;
      6'h10: begin
        d.cp0 = 1'b1; d.serial = 1'b1;
        if (rs == 5'h00) d.waddr = rt;
        else if (rs == 5'h04) d.rt = rt;
        else if (rs == 5'h10 &&
                 (fn == 6'h18 || fn == 6'h01 ||
                  fn == 6'h02 || fn == 6'h08))
          d.cp0 = 1'b1;
        else d.inv = 1'b1;
      end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
        d.waddr = rt; d.rs = rs; d.mem = 1'b1;
      end
      6'h28, 6'h29, 6'h2b: begin
        d.rs = rs; d.rt = rt; d.mem = 1'b1;
      end
      6'h2f: begin
        d.rs = rs; d.mem = 1'b1; d.serial = 1'b1;
      end
      default: d.inv = 1'b1;
    endcase
    d.serial = d.serial | d.inv;
    return d;
  endfunction

  logic [PW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]  cnt_q, cnt_d, enq_n, deq_n;
  logic [FCW-1:0] fcnt;
  logic           do_enq;
  logic [31:0]    pc_mem   [DEPTH];
  logic [31:0]    inst_mem [DEPTH];
  logic [31:0]    s_pc     [ISSUE_W];
  logic [31:0]    s_inst   [ISSUE_W];
  dec_t           dec      [ISSUE_W];
  logic [ISSUE_W-1:0] occ;
  logic           two_occ;

  assign fcnt = (fetch_cnt > FCW'(FETCH_W)) ?
                FCW'(FETCH_W) : fetch_cnt;
  assign fetch_ready = cnt_q <= CW'(DEPTH - FETCH_W);
  assign do_enq = fetch_valid & fetch_ready & ~flush;
  assign enq_n  = do_enq ? CW'(fcnt) : '0;
  assign deq_n  = (issue_accept & ~flush) ?
                  CW'($countones(issue_valid)) : '0;
  assign two_occ = cnt_q >= CW'(2);
  assign count   = cnt_q;

  // pointer and occupancy next state; flush wins over traffic
  always_comb begin
    head_d = head_q + PW'(deq_n);
    tail_d = tail_q + PW'(enq_n);
    cnt_d  = cnt_q + enq_n - deq_n;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end
  end

  // queue control registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // entry storage, written lowest lanes first from tail
  always_ff @(posedge clk) begin
    if (do_enq) begin
      for (int l = 0; l < FETCH_W; l++) begin
        if (FCW'(l) < fcnt) begin
          pc_mem[tail_q + PW'(l)]   <= fetch_pc[32*l +: 32];
          inst_mem[tail_q + PW'(l)] <= fetch_inst[32*l +: 32];
        end
      end
    end
  end

  // read the oldest entries and pre-decode them
  always_comb begin
    for (int k = 0; k < ISSUE_W; k++) begin
      s_pc[k]   = pc_mem[head_q + PW'(k)];
      s_inst[k] = inst_mem[head_q + PW'(k)];
      dec[k]    = predecode(s_inst[k]);
      occ[k]    = cnt_q > CW'(k);
    end
  end

  // pairing rules: build the legal contiguous prefix
  always_comb begin
    logic        ser_seen, mem_seen, hilo_seen;
    logic        blocked, ok, hold_br;
    logic [31:0] wmask;
    ser_seen  = 1'b0;
    mem_seen  = 1'b0;
    hilo_seen = 1'b0;
    blocked   = 1'b0;
    ok        = 1'b0;
    wmask     = '0;
    // a lone branch waits for its delay slot
    hold_br   = dec[0].branch & ~dec[0].serial &
                (ISSUE_W > 1) & ~two_occ & ~flush;
    issue_valid = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      if (k == 0) begin
        ok = occ[0] & ~hold_br;
      end else begin
        ok = ~blocked & occ[k] & ~ser_seen &
             ~dec[k].serial & ~dec[k].branch &
             ~(mem_seen & dec[k].mem) &
             ~(hilo_seen & dec[k].hilo) &
             ~wmask[dec[k].rs] & ~wmask[dec[k].rt];
      end
      issue_valid[k] = ok;
      blocked   = blocked | ~ok;
      ser_seen  = ser_seen | dec[k].serial;
      mem_seen  = mem_seen | dec[k].mem;
      hilo_seen = hilo_seen | dec[k].hilo;
      if (dec[k].waddr != 5'd0)
        wmask[dec[k].waddr] = 1'b1;
    end
  end

  // pack per-slot fields onto the issue buses
  always_comb begin
    for (int k = 0; k < ISSUE_W; k++) begin
      issue_pc[32*k +: 32]   = s_pc[k];
      issue_inst[32*k +: 32] = s_inst[k];
      issue_waddr[5*k +: 5]  = dec[k].waddr;
      issue_raddr[10*k +: 10] = {dec[k].rs, dec[k].rt};
      issue_class[6*k +: 6]  = {dec[k].serial,
                                dec[k].branch,
                                dec[k].mem,
                                dec[k].hilo,
                                dec[k].cp0,
                                dec[k].inv};
    end
  end
endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: table vectors, directed corner sequences
// and a random run against a queue-based reference model.
module tb_decode_queue;
  localparam int DEPTH = 8;
  localparam int FW    = 2;
  localparam int IW    = 2;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        flush = 1'b0;
  logic        fetch_valid = 1'b0;
  logic [1:0]  fetch_cnt = '0;
  logic [63:0] fetch_pc = '0;
  logic [63:0] fetch_inst = '0;
  logic        fetch_ready;
  logic [1:0]  issue_valid;
  logic [63:0] issue_pc, issue_inst;
  logic [9:0]  issue_waddr;
  logic [19:0] issue_raddr;
  logic [11:0] issue_class;
  logic        issue_accept = 1'b0;
  logic [3:0]  count;

  int checks = 0;
  int errors = 0;

  decode_queue #(.DEPTH(DEPTH), .FETCH_W(FW), .ISSUE_W(IW)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .fetch_valid(fetch_valid), .fetch_cnt(fetch_cnt),
    .fetch_pc(fetch_pc), .fetch_inst(fetch_inst),
    .fetch_ready(fetch_ready), .issue_valid(issue_valid),
    .issue_pc(issue_pc), .issue_inst(issue_inst),
    .issue_waddr(issue_waddr), .issue_raddr(issue_raddr),
    .issue_class(issue_class), .issue_accept(issue_accept),
    .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] fn,
      input logic [4:0] rs, rt, rd);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op,
      input logic [4:0] rs, rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_mfc0(input logic [4:0] rt, rd);
    return {6'h10, 5'h00, rt, rd, 11'h0};
  endfunction

  // class bit values {serial,branch,mem,hilo,cp0,invalid}
  localparam logic [5:0] C_SER = 6'b100000;
  localparam logic [5:0] C_BR  = 6'b010000;
  localparam logic [5:0] C_MEM = 6'b001000;
  localparam logic [5:0] C_HL  = 6'b000100;
  localparam logic [5:0] C_CP0 = 6'b000010;
  localparam logic [5:0] C_INV = 6'b000001;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  w;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [5:0]  cls;
  } rec_t;

  rec_t mq[$];

  // instruction by mnemonic, with its architectural meaning
  function automatic rec_t gen(input int kind,
      input logic [4:0] a, b, c);
    rec_t r;
    r = '0;
    case (kind)
      1: begin
        r.inst = enc_i(6'h23, a, c, 16'h4);
        r.w = c; r.rs = a; r.cls = C_MEM;
      end
      2: begin
        r.inst = enc_i(6'h2b, a, b, 16'h8);
        r.rs = a; r.rt = b; r.cls = C_MEM;
      end
      3: begin
        r.inst = enc_r(6'h18, a, b, 5'd0);
        r.rs = a; r.rt = b; r.cls = C_HL;
      end
      4: begin
        r.inst = enc_r(6'h12, 5'd0, 5'd0, c);
        r.w = c; r.cls = C_HL;
      end
      5: begin
        r.inst = enc_i(6'h04, a, b, 16'h8);
        r.rs = a; r.rt = b; r.cls = C_BR;
      end
      6: begin
        r.inst = {6'h03, 26'h40};
        r.w = 5'd31; r.cls = C_BR;
      end
      7: begin
        r.inst = enc_mfc0(c, 5'd12);
        r.w = c; r.cls = C_SER | C_CP0;
      end
      8: begin
        r.inst = enc_i(6'h0d, a, c, 16'h5);
        r.w = c; r.rs = a;
      end
      9: begin
        r.inst = 32'h0000000c;
        r.cls = C_SER;
      end
      default: begin
        r.inst = enc_r(6'h21, a, b, c);
        r.w = c; r.rs = a; r.rt = b;
      end
    endcase
    return r;
  endfunction

  // oldest-first walk of the model queue applying pairing rules
  function automatic logic [1:0] exp_valid(input logic fl);
    logic [1:0]  v;
    logic [31:0] wr;
    bit          ser, mem, hl;
    rec_t        r;
    v = '0; wr = '0; ser = 0; mem = 0; hl = 0;
    for (int k = 0; k < IW; k++) begin
      if (k >= mq.size()) break;
      r = mq[k];
      if (k == 0) begin
        if (r.cls[4] && !r.cls[5] && mq.size() < 2 && !fl) break;
      end else begin
        if (r.cls[5] || ser || r.cls[4]) break;
        if (mem && r.cls[3]) break;
        if (hl && r.cls[2]) break;
        if (r.rs != 0 && wr[r.rs]) break;
        if (r.rt != 0 && wr[r.rt]) break;
      end
      v[k] = 1'b1;
      if (r.cls[5]) ser = 1;
      if (r.cls[3]) mem = 1;
      if (r.cls[2]) hl = 1;
      if (r.w != 0) wr[r.w] = 1'b1;
    end
    return v;
  endfunction

  task automatic idle();
    fetch_valid = 1'b0;
    fetch_cnt = '0;
    issue_accept = 1'b0;
    flush = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    idle();
    #1;
  endtask

  task automatic push(input logic [31:0] i0, i1,
      input logic [31:0] p0, input logic [1:0] n);
    fetch_inst = {i1, i0};
    fetch_pc = {p0 + 32'd4, p0};
    fetch_cnt = n;
    fetch_valid = 1'b1;
    cyc();
  endtask

  task automatic do_flush();
    flush = 1'b1;
    cyc();
  endtask

  typedef struct packed {
    logic [31:0] i0;
    logic [31:0] i1;
    logic [1:0]  v;
    logic [4:0]  w0;
    logic [9:0]  r0;
    logic [5:0]  c0;
  } vec_t;

  vec_t tbl[16];

  initial begin
    logic [31:0] addu_i;
    logic [31:0] beq_i;
    logic [1:0]  ev;
    logic        rdy;
    logic [31:0] next_pc;
    rec_t        lane[2];
    int          fc;

    tbl[0]  = '{enc_r(6'h21,1,2,3), enc_r(6'h21,3,5,4),
                2'b01, 5'd3, {5'd1,5'd2}, 6'b0};
    tbl[1]  = '{enc_r(6'h21,1,2,3), enc_r(6'h21,4,5,6),
                2'b11, 5'd3, {5'd1,5'd2}, 6'b0};
    tbl[2]  = '{enc_i(6'h23,1,2,0), enc_i(6'h2b,5,4,4),
                2'b01, 5'd2, {5'd1,5'd0}, C_MEM};
    tbl[3]  = '{enc_mfc0(2,12), enc_r(6'h21,1,2,3),
                2'b01, 5'd2, 10'd0, C_SER | C_CP0};
    tbl[4]  = '{enc_i(6'h04,1,2,4), 32'h0,
                2'b11, 5'd0, {5'd1,5'd2}, C_BR};
    tbl[5]  = '{enc_r(6'h21,1,2,3), enc_i(6'h04,4,5,4),
                2'b01, 5'd3, {5'd1,5'd2}, 6'b0};
    tbl[6]  = '{enc_r(6'h18,1,2,0), enc_r(6'h12,0,0,3),
                2'b01, 5'd0, {5'd1,5'd2}, C_HL};
    tbl[7]  = '{enc_i(6'h23,1,2,0), enc_r(6'h21,2,5,4),
                2'b01, 5'd2, {5'd1,5'd0}, C_MEM};
    tbl[8]  = '{32'h0000000c, enc_r(6'h21,1,2,3),
                2'b01, 5'd0, 10'd0, C_SER};
    tbl[9]  = '{enc_r(6'h21,1,2,3), 32'h0000000c,
                2'b01, 5'd3, {5'd1,5'd2}, 6'b0};
    tbl[10] = '{enc_r(6'h21,1,2,0), enc_r(6'h21,0,0,4),
                2'b11, 5'd0, {5'd1,5'd2}, 6'b0};
    tbl[11] = '{32'hfc000000, enc_r(6'h21,1,2,3),
                2'b01, 5'd0, 10'd0, C_SER | C_INV};
    tbl[12] = '{{6'h03,26'h40}, enc_r(6'h21,31,1,4),
                2'b01, 5'd31, 10'd0, C_BR};
    tbl[13] = '{enc_i(6'h0d,1,5,16), enc_r(6'h21,5,0,6),
                2'b01, 5'd5, {5'd1,5'd0}, 6'b0};
    tbl[14] = '{enc_r(6'h21,1,2,3), enc_i(6'h23,4,3,0),
                2'b11, 5'd3, {5'd1,5'd2}, 6'b0};
    tbl[15] = '{enc_i(6'h23,1,2,0), enc_r(6'h21,4,5,6),
                2'b11, 5'd2, {5'd1,5'd0}, C_MEM};

    // asynchronous reset state
    #1 resetn = 1'b0;
    #2;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ready", 64'(fetch_ready), 64'd1);
    chk("rst_valid", 64'(issue_valid), 64'd0);
    @(posedge clk);
    #1 resetn = 1'b1;
    #1;

    // fill to full with independent addu
    for (int b = 0; b < 4; b++) begin
      push(enc_r(6'h21, 1, 2, 5'(10 + 2*b)),
           enc_r(6'h21, 1, 2, 5'(11 + 2*b)),
           32'h100 + 32'(8*b), 2'd2);
      chk($sformatf("fill_cnt%0d", b), 64'(count), 64'(2*b + 2));
    end
    chk("full_ready", 64'(fetch_ready), 64'd0);
    chk("full_valid", 64'(issue_valid), 64'd3);
    chk("full_pc0", 64'(issue_pc[31:0]), 64'h100);
    push(32'h0, 32'h0, 32'h200, 2'd2);
    chk("full_ignore", 64'(count), 64'd8);
    issue_accept = 1'b1;
    cyc();
    chk("acc_count", 64'(count), 64'd6);
    chk("acc_ready", 64'(fetch_ready), 64'd1);
    chk("acc_pc0", 64'(issue_pc[31:0]), 64'h108);
    do_flush();

    // pair table
    for (int t = 0; t < 16; t++) begin
      push(tbl[t].i0, tbl[t].i1, 32'h400, 2'd2);
      chk($sformatf("v%0d_valid", t), 64'(issue_valid),
          64'(tbl[t].v));
      chk($sformatf("v%0d_waddr", t), 64'(issue_waddr[4:0]),
          64'(tbl[t].w0));
      chk($sformatf("v%0d_raddr", t), 64'(issue_raddr[9:0]),
          64'(tbl[t].r0));
      chk($sformatf("v%0d_class", t), 64'(issue_class[5:0]),
          64'(tbl[t].c0));
      do_flush();
    end

    // RAW pair: second issues alone after the first leaves
    addu_i = enc_r(6'h21, 3, 5, 4);
    push(enc_r(6'h21, 1, 2, 3), addu_i, 32'h500, 2'd2);
    issue_accept = 1'b1;
    cyc();
    chk("raw_valid", 64'(issue_valid), 64'd1);
    chk("raw_inst0", 64'(issue_inst[31:0]), 64'(addu_i));
    chk("raw_pc0", 64'(issue_pc[31:0]), 64'h504);
    do_flush();

    // serializing op then addu alone
    addu_i = enc_r(6'h21, 1, 2, 3);
    push(enc_mfc0(2, 12), addu_i, 32'h600, 2'd2);
    chk("ser_valid", 64'(issue_valid), 64'd1);
    issue_accept = 1'b1;
    cyc();
    chk("ser_next", 64'(issue_valid), 64'd1);
    chk("ser_inst0", 64'(issue_inst[31:0]), 64'(addu_i));
    chk("ser_count", 64'(count), 64'd1);
    do_flush();

    // branch waits for its delay slot
    beq_i = enc_i(6'h04, 1, 2, 16'h10);
    push(beq_i, 32'h0, 32'h700, 2'd1);
    chk("br_alone", 64'(issue_valid), 64'd0);
    chk("br_count", 64'(count), 64'd1);
    flush = 1'b1;
    #1;
    chk("br_flush", 64'(issue_valid), 64'd1);
    flush = 1'b0;
    #1;
    push(32'h0, 32'h0, 32'h704, 2'd1);
    chk("br_pair", 64'(issue_valid), 64'd3);
    chk("br_inst0", 64'(issue_inst[31:0]), 64'(beq_i));
    do_flush();

    // zero-count bundle is a no-op
    push(32'h0, 32'h0, 32'h780, 2'd0);
    chk("cnt0", 64'(count), 64'd0);

    // flush with five entries and a bundle arriving
    push(addu_i, addu_i, 32'h800, 2'd2);
    push(addu_i, addu_i, 32'h808, 2'd2);
    push(addu_i, addu_i, 32'h810, 2'd1);
    chk("fl_pre", 64'(count), 64'd5);
    flush = 1'b1;
    fetch_valid = 1'b1;
    fetch_cnt = 2'd2;
    issue_accept = 1'b1;
    cyc();
    chk("fl_count", 64'(count), 64'd0);
    chk("fl_valid", 64'(issue_valid), 64'd0);
    chk("fl_ready", 64'(fetch_ready), 64'd1);

    // asynchronous reset mid-stream
    push(addu_i, addu_i, 32'h900, 2'd2);
    push(addu_i, addu_i, 32'h908, 2'd2);
    #2 resetn = 1'b0;
    #1;
    chk("ar_count", 64'(count), 64'd0);
    chk("ar_valid", 64'(issue_valid), 64'd0);
    chk("ar_ready", 64'(fetch_ready), 64'd1);
    @(posedge clk);
    #1 resetn = 1'b1;
    #1;

    // random traffic against the reference queue
    mq.delete();
    next_pc = 32'h1000;
    for (int c = 0; c < 500; c++) begin
      for (int l = 0; l < 2; l++) begin
        fc = $urandom_range(0, 12);
        lane[l] = gen(fc > 9 ? 0 : fc,
                      5'($urandom_range(0, 7)),
                      5'($urandom_range(0, 7)),
                      5'($urandom_range(0, 7)));
        lane[l].pc = next_pc + 32'(4*l);
        fetch_pc[32*l +: 32] = lane[l].pc;
        fetch_inst[32*l +: 32] = lane[l].inst;
      end
      fc = $urandom_range(0, 2);
      fetch_cnt = 2'(fc);
      fetch_valid = ($urandom_range(0, 3) != 0);
      issue_accept = ($urandom_range(0, 9) < 6);
      flush = ($urandom_range(0, 59) == 0);
      #1;
      ev = exp_valid(flush);
      rdy = (DEPTH - mq.size()) >= FW;
      chk("r_count", 64'(count), 64'(mq.size()));
      chk("r_ready", 64'(fetch_ready), 64'(rdy));
      chk("r_valid", 64'(issue_valid), 64'(ev));
      for (int k = 0; k < IW; k++) begin
        if (ev[k]) begin
          chk($sformatf("r_pc%0d", k),
              64'(issue_pc[32*k +: 32]), 64'(mq[k].pc));
          chk($sformatf("r_inst%0d", k),
              64'(issue_inst[32*k +: 32]), 64'(mq[k].inst));
          chk($sformatf("r_waddr%0d", k),
              64'(issue_waddr[5*k +: 5]), 64'(mq[k].w));
          chk($sformatf("r_raddr%0d", k),
              64'(issue_raddr[10*k +: 10]),
              64'({mq[k].rs, mq[k].rt}));
          chk($sformatf("r_class%0d", k),
              64'(issue_class[6*k +: 6]), 64'(mq[k].cls));
        end
      end
      @(posedge clk);
      if (flush) begin
        mq.delete();
      end else begin
        if (issue_accept)
          for (int k = 0; k < $countones(ev); k++)
            void'(mq.pop_front());
        if (fetch_valid && rdy) begin
          for (int l = 0; l < fc; l++) mq.push_back(lane[l]);
          next_pc = next_pc + 32'(4*fc);
        end
      end
      #1;
    end
    idle();
    #1;

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
